// File: rtl/w0rm_mmio_responder.sv
// MMIO responder: 16-byte window with LED, cycle counter, scratch and sticky status registers.
// Latency: response strobe 1+WAIT_STATES cycles after request accept, one cycle wide.
// Backpressure: none; a single request may be outstanding, hits while waiting are dropped and flagged OVERRUN.
module w0rm_mmio_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        core_clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        mem_valid_i,
  output logic [31:0] mem_data_o,
  output logic        mem_valid_o,
  output logic [7:0]  leds
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;

  logic [31:0] cycle_cnt;
  logic [31:0] scratch_q;
  logic [1:0]  status_q;

  logic        hit;
  logic        accept;
  logic        misalign;
  logic        wr_en;
  logic        overrun_set;
  logic        misalign_set;
  logic [1:0]  reg_sel;
  logic [31:0] rd_val;
  logic [1:0]  status_clr;
  logic [1:0]  status_nxt;

  // Request decode: window hit, accept only when not already waiting on a response.
  always_comb begin
    hit          = mem_valid_i & (mem_read_i | mem_write_i) &
                   (mem_addr_i[31:4] == BASE_ADDR[31:4]);
    accept       = hit & (state != S_WAIT);
    misalign     = (mem_addr_i[1:0] != 2'b00);
    reg_sel      = mem_addr_i[3:2];
    wr_en        = accept & mem_write_i & ~misalign;
    overrun_set  = hit & (state == S_WAIT);
    misalign_set = accept & misalign;
  end

  // Read mux: value of the addressed register before any write on this edge.
  always_comb begin
    rd_val = 32'h0;
    if (!misalign) begin
      case (reg_sel)
        2'd0:    rd_val = {24'h0, leds};
        2'd1:    rd_val = cycle_cnt;
        2'd2:    rd_val = scratch_q;
        default: rd_val = {30'h0, status_q};
      endcase
    end
  end

  // Sticky status: W1C clears, but a set on the same edge takes priority.
  always_comb begin
    status_clr = 2'b00;
    if (wr_en && reg_sel == 2'd3) status_clr = mem_data_i[1:0];
    status_nxt = (status_q & ~status_clr) | {misalign_set, overrun_set};
  end

  // FSM state and wait counter registers.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // FSM next state: accept from IDLE or RESP, count down wait states, strobe in RESP.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_valid_o  = 1'b0;
    case (state)
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        mem_valid_o = 1'b1;
        state_nxt   = S_IDLE;
        if (accept) begin
          if (WS == 4'd0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WS;
          end
        end
      end
      default: begin
        if (accept) begin
          if (WS == 4'd0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WS;
          end
        end
      end
    endcase
  end

  // Register file, cycle counter and captured read data.
  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      leds       <= 8'h0;
      scratch_q  <= 32'h0;
      cycle_cnt  <= 32'h0;
      status_q   <= 2'b00;
      mem_data_o <= 32'h0;
    end else begin
      status_q <= status_nxt;
      if (wr_en && reg_sel == 2'd1) cycle_cnt <= 32'h0;
      else                          cycle_cnt <= cycle_cnt + 32'd1;
      if (wr_en && reg_sel == 2'd0) leds      <= mem_data_i[7:0];
      if (wr_en && reg_sel == 2'd2) scratch_q <= mem_data_i;
      if (accept)                   mem_data_o <= rd_val;
    end
  end

endmodule

// File: tb/tb_w0rm_mmio_responder.sv
// Directed bench for w0rm_mmio_responder: one zero-wait instance at 0x1000, one 3-wait instance at 0x2000.
// Inputs are driven on the falling edge and outputs sampled on the next falling edge.
// Both instances share the request bus; their windows do not overlap.
module tb_w0rm_mmio_responder;

  logic        core_clk;
  logic        reset;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic        mem_valid_i;

  logic [31:0] d0, d3;
  logic        v0, v3;
  logic [7:0]  l0, l3;

  int checks   = 0;
  int failures = 0;

  w0rm_mmio_responder #(.BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) dut0 (
    .core_clk    (core_clk),
    .reset       (reset),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_o  (d0),
    .mem_valid_o (v0),
    .leds        (l0)
  );

  w0rm_mmio_responder #(.BASE_ADDR(32'h0000_2000), .WAIT_STATES(3)) dut3 (
    .core_clk    (core_clk),
    .reset       (reset),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .mem_valid_i (mem_valid_i),
    .mem_data_o  (d3),
    .mem_valid_o (v3),
    .leds        (l3)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data);
    mem_valid_i = rd | wr;
    mem_read_i  = rd;
    mem_write_i = wr;
    mem_addr_i  = addr;
    mem_data_i  = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(negedge core_clk);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    idle();
    step(); step();
    chk("rst_vld0", {31'h0, v0}, 32'h0);
    chk("rst_vld3", {31'h0, v3}, 32'h0);
    chk("rst_dat0", d0, 32'h0);
    chk("rst_leds", {24'h0, l0}, 32'h0);
    reset = 1'b0;
    step();

    // LED write then back-to-back read
    drive(1'b0, 1'b1, 32'h0000_1000, 32'h0000_00A5);
    step();
    chk("led_wr_vld", {31'h0, v0}, 32'h1);
    chk("leds_upd",   {24'h0, l0}, 32'h0000_00A5);
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    step();
    chk("led_rd_vld", {31'h0, v0}, 32'h1);
    chk("led_rd_dat", d0, 32'h0000_00A5);
    idle();
    step();
    chk("vld_one_cyc", {31'h0, v0}, 32'h0);
    chk("dat_hold",    d0, 32'h0000_00A5);

    // Scratch write/read back to back
    drive(1'b0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF);
    step();
    drive(1'b1, 1'b0, 32'h0000_1008, 32'h0);
    step();
    chk("scr_rd_vld", {31'h0, v0}, 32'h1);
    chk("scr_rd_dat", d0, 32'hDEAD_BEEF);

    // Cycle counter clear, then read two accepts later
    drive(1'b0, 1'b1, 32'h0000_1004, 32'h1234_5678);
    step();
    drive(1'b1, 1'b0, 32'h0000_100C, 32'h0);
    step();
    chk("status_clean", d0, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    step();
    chk("cyc_after_clr", d0, 32'h1);

    // Misaligned read, MISALIGN flag, W1C clear
    drive(1'b1, 1'b0, 32'h0000_1009, 32'h0);
    step();
    chk("mis_vld", {31'h0, v0}, 32'h1);
    chk("mis_dat", d0, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_100C, 32'h0);
    step();
    chk("mis_flag", d0, 32'h2);
    drive(1'b0, 1'b1, 32'h0000_100C, 32'h2);
    step();
    drive(1'b1, 1'b0, 32'h0000_100C, 32'h0);
    step();
    chk("w1c_clr", d0, 32'h0);

    // Outside both windows: no response, no flag
    drive(1'b1, 1'b0, 32'h0000_1010, 32'h0);
    step();
    chk("miss_vld0", {31'h0, v0}, 32'h0);
    chk("miss_vld3", {31'h0, v3}, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_100C, 32'h0);
    step();
    chk("miss_noflag", d0, 32'h0);

    // Read+write: old value returned, new value stored
    drive(1'b1, 1'b1, 32'h0000_1008, 32'h1234_5678);
    step();
    chk("rmw_old", d0, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h0000_1008, 32'h0);
    step();
    chk("rmw_new", d0, 32'h1234_5678);
    idle();
    step();

    // Three wait states: accept at T, strobe only in T+4; hit at T+2 sets OVERRUN
    drive(1'b1, 1'b0, 32'h0000_2008, 32'h0);
    step();
    idle();
    chk("ws_t1", {31'h0, v3}, 32'h0);
    step();
    chk("ws_t2", {31'h0, v3}, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_200C, 32'h0);
    step();
    idle();
    chk("ws_t3", {31'h0, v3}, 32'h0);
    step();
    chk("ws_t4", {31'h0, v3}, 32'h1);
    step();
    chk("ws_t5", {31'h0, v3}, 32'h0);
    step();
    chk("ws_no_extra", {31'h0, v3}, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_200C, 32'h0);
    step();
    idle();
    step(); step();
    chk("ovr_pre", {31'h0, v3}, 32'h0);
    step();
    chk("ovr_vld", {31'h0, v3}, 32'h1);
    chk("ovr_flag", d3, 32'h1);
    step();

    // Reset during WAIT abandons the pending response
    drive(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    step();
    idle();
    step();
    reset = 1'b1;
    #1;
    chk("arst_vld3", {31'h0, v3}, 32'h0);
    chk("arst_dat3", d3, 32'h0);
    chk("arst_dat0", d0, 32'h0);
    chk("arst_leds", {24'h0, l0}, 32'h0);
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (v3 || v0) seen = 1'b1;
    end
    chk("arst_no_resp", {31'h0, seen}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/w0rm_mmio_responder.md
# w0rm_mmio_responder

Memory-mapped I/O responder on the W0RM core data-memory bus: it answers the core's `mem_*` request handshake for a 16-byte register window, the way the block RAM does for main memory. The window holds an 8-bit LED register, a free-running cycle counter, a scratch word and a sticky status word. It sits beside main memory on the core's data bus, selected by `BASE_ADDR`. Response latency is configurable through `WAIT_STATES` to emulate slow peripherals.

## Interface
- `BASE_ADDR`, 32'h0000_1000: window base; bits [3:0] ignored.
- `WAIT_STATES`, 0: extra cycles between request accept and response, 0..15.
- `core_clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `mem_addr_i` input 32: request byte address, from core `mem_addr_o`.
- `mem_data_i` input 32: write data, from core `mem_data_o`.
- `mem_read_i` input 1: read request qualifier.
- `mem_write_i` input 1: write request qualifier.
- `mem_valid_i` input 1: request strobe, from core `mem_valid_o`.
- `mem_data_o` output 32: read data, valid while `mem_valid_o` is high.
- `mem_valid_o` output 1: one-cycle response strobe, to core `mem_valid_i`.
- `leds` output 8: LED register contents.

## Operation
- Hit: `mem_valid_i & (mem_read_i | mem_write_i) & (mem_addr_i[31:4] == BASE_ADDR[31:4])`.
  - A non-hit is ignored entirely: no response and no flag.
- Register map, decoded from `mem_addr_i[3:2]`:
  - 0x0 LED: RW. Bits [7:0] are stored; reads return zero-extended.
  - 0x4 CYCLES: reads return the counter value. Any write clears it to 0.
  - 0x8 SCRATCH: RW, 32 bits.
  - 0xC STATUS: bit0 OVERRUN, bit1 MISALIGN. Write-1-to-clear; other bits read 0.
- Misaligned hit (`mem_addr_i[1:0] != 0`):
  - Response is still issued, with data 0.
  - Any write is discarded.
  - MISALIGN is set.
- Read and write both high: performed as a write. The returned data is the register value before the write.
- State machine:
  - IDLE: a hit is accepted. Go to RESP if `WAIT_STATES == 0`; otherwise go to WAIT and load the wait counter with `WAIT_STATES`.
  - WAIT: decrement the wait counter each cycle. When it reaches 1, go to RESP.
  - RESP: `mem_valid_o = 1`. A hit in this cycle is accepted exactly as in IDLE. With no hit, go to IDLE.
- One outstanding request only. A hit during WAIT is dropped (no response) and sets OVERRUN.
- Accept edge:
  - Read data is captured into `mem_data_o`.
  - The write is committed.
- Cycle counter:
  - Increments every cycle and wraps 0xFFFF_FFFF→0.
  - A write to CYCLES overrides the increment; the counter is 0 in the next cycle.
- Flag set and W1C clear on the same edge: set wins.

## Timing
- Reset values: `mem_valid_o` 0, `mem_data_o` 0, `leds` 0, CYCLES 0, SCRATCH 0, STATUS 0, state IDLE.
- Reset asserted mid-transaction: the pending response is abandoned and no `mem_valid_o` is issued after reset release.
- Latency: a request accepted at edge T gives `mem_valid_o` high in cycle T+1+`WAIT_STATES`, for exactly one cycle.
- Write visibility:
  - `leds` and the registers update in cycle T+1.
  - A read accepted at edge T+1 sees the new value.
- Throughput:
  - `WAIT_STATES = 0`: one request per cycle (back-to-back supported via RESP→RESP).
  - Otherwise: one request per `WAIT_STATES+1` cycles.
- CYCLES read at accept edge T returns the counter value present in cycle T.
- `mem_data_o` holds its last value when `mem_valid_o` is low.

## Test plan
- Reset, then write 0xA5 to BASE+0x0 (`WAIT_STATES` 0) → `mem_valid_o` pulses one cycle after accept; `leds` = 0xA5 the next cycle; a read of 0x0 returns 0x0000_00A5.
- Write 0xDEAD_BEEF to BASE+0x8, then read it back to back on consecutive cycles → read response in the cycle after the write response, with data 0xDEAD_BEEF.
- `WAIT_STATES` 3, read accepted at edge T → `mem_valid_o` high only in cycle T+4. A second hit at T+2 → no extra response, and a later STATUS read returns 0x1.
- Write any value to BASE+0x4, then read it two accepts later → read returns 1. Counter forced to 0xFFFF_FFFF rolls to 0 on the next cycle.
- Read BASE+0x9 → response data 0, STATUS = 0x2. Write 0x2 to BASE+0xC → STATUS reads 0. Access to BASE+0x10 → no response, no flag.
- Assert `reset` during WAIT → outputs go to 0 immediately and no response follows after release. Read+write to 0x8 → old value returned, new value stored.
